// File: rtl/instr_exec_unit.sv
`timescale 1ns/1ps
// instr_exec_unit: execution stage behind the instruction register (single-cycle ALU, pipelined MULT, iterative DIV/MOD).
// Optional feature: define INSTR_EXEC_STATS_EN to add the exec_count / dz_count handshake counters.
module instr_exec_unit #(
  parameter int TAG_W      = 5,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [31:0]      in_operand_a,
  input  logic [31:0]      in_operand_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_by_zero,
  output logic             out_illegal_op,
  output logic             busy
`ifdef INSTR_EXEC_STATS_EN
  ,
  output logic [31:0]      exec_count,
  output logic [15:0]      dz_count
`endif
);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  localparam logic [4:0] MUL_LAST = (MUL_CYCLES >= 2) ? 5'(MUL_CYCLES - 2) : 5'd0;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               is_mul_q, is_mul_d;
  logic               is_mod_q, is_mod_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        quo_q, quo_d;
  logic [31:0]        dvs_q, dvs_d;
  logic [63:0]        result_q, result_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dz_q, dz_d;
  logic               ill_q, ill_d;

  logic [31:0]        mul_a, mul_b;
  logic [63:0]        product;
  logic [63:0]        step_first, step_next;
  logic               handshake;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] apply_sign(input logic neg, input logic [31:0] m);
    return neg ? (64'd0 - {32'd0, m}) : {32'd0, m};
  endfunction

  // One restoring step on magnitudes: returns {remainder, dividend/quotient shift register}.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {rem, quo[31]};
    diff  = trial - {1'b0, dvs};
    if (!diff[32]) return {diff[31:0], quo[30:0], 1'b1};
    else           return {trial[31:0], quo[30:0], 1'b0};
  endfunction

  // With MUL_CYCLES == 1 the product is taken straight from the inputs at acceptance.
  assign mul_a      = (state_q == IDLE) ? in_operand_a : a_q;
  assign mul_b      = (state_q == IDLE) ? in_operand_b : b_q;
  assign product    = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
  assign step_first = div_step(32'd0, mag(in_operand_a), mag(in_operand_b));
  assign step_next  = div_step(rem_q, quo_q, dvs_q);
  assign handshake  = (state_q == DONE) && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mul_d  = is_mul_q;
    is_mod_d  = is_mod_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    tag_d     = tag_q;
    dz_d      = dz_q;
    ill_d     = ill_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tag_d     = in_tag;
          dz_d      = 1'b0;
          ill_d     = 1'b0;
          result_d  = 64'd0;
          cnt_d     = 5'd0;
          is_mul_d  = 1'b0;
          is_mod_d  = (in_opcode == OP_MOD);
          neg_quo_d = in_operand_a[31] ^ in_operand_b[31];
          neg_rem_d = in_operand_a[31];
          a_d       = in_operand_a;
          b_d       = in_operand_b;
          dvs_d     = mag(in_operand_b);
          state_d   = DONE;
          case (in_opcode)
            OP_ZERO:  result_d = 64'd0;
            OP_PASSA: result_d = {{32{in_operand_a[31]}}, in_operand_a};
            OP_PASSB: result_d = {{32{in_operand_b[31]}}, in_operand_b};
            OP_ADD:   result_d = {{32{in_operand_a[31]}}, in_operand_a}
                               + {{32{in_operand_b[31]}}, in_operand_b};
            OP_SUB:   result_d = {{32{in_operand_a[31]}}, in_operand_a}
                               - {{32{in_operand_b[31]}}, in_operand_b};
            OP_MULT: begin
              if (MUL_CYCLES <= 1) begin
                result_d = product;
              end else begin
                is_mul_d = 1'b1;
                state_d  = EXEC;
              end
            end
            OP_DIV, OP_MOD: begin
              if (in_operand_b == 32'd0) begin
                dz_d = 1'b1;
              end else begin
                {rem_d, quo_d} = step_first;
                state_d        = EXEC;
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_mul_q) begin
          if (cnt_q == MUL_LAST) begin
            result_d = product;
            state_d  = DONE;
          end
        end else if (cnt_q == 5'd31) begin
          // All 32 magnitude steps are done; this edge only restores signs.
          result_d = is_mod_q ? apply_sign(neg_rem_q, rem_q) : apply_sign(neg_quo_q, quo_q);
          state_d  = DONE;
        end else begin
          {rem_d, quo_d} = step_next;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_mul_q  <= 1'b0;
      is_mod_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      result_q  <= 64'd0;
      tag_q     <= '0;
      dz_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mul_q  <= is_mul_d;
      is_mod_q  <= is_mod_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      dz_q      <= dz_d;
      ill_q     <= ill_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign out_result      = result_q;
  assign out_tag         = tag_q;
  assign out_div_by_zero = dz_q;
  assign out_illegal_op  = ill_q;

`ifdef INSTR_EXEC_STATS_EN
  logic [31:0] exec_count_q, exec_count_d;
  logic [15:0] dz_count_q, dz_count_d;

  always_comb begin
    exec_count_d = exec_count_q;
    dz_count_d   = dz_count_q;
    if (handshake) begin
      exec_count_d = exec_count_q + 32'd1;
      if (dz_q && (dz_count_q != 16'hFFFF)) dz_count_d = dz_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_count_q <= 32'd0;
      dz_count_q   <= 16'd0;
    end else begin
      exec_count_q <= exec_count_d;
      dz_count_q   <= dz_count_d;
    end
  end

  assign exec_count = exec_count_q;
  assign dz_count   = dz_count_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
